// File: rtl/loteria_sequenciador_if.sv
// rtl/loteria_sequenciador_if.sv - handshake/bus bundle between the bet front end and the lottery sequencer
interface loteria_sequenciador_if #(
  parameter int DIGIT_W = 4,
  parameter int CNT_W   = 5
);
  logic               cfg_we;
  logic [2:0]         cfg_idx;
  logic [DIGIT_W-1:0] cfg_val;
  logic [DIGIT_W-1:0] numero;
  logic               insere;
  logic               insere_rdy;
  logic               fim_jogo;
  logic [1:0]         premio;
  logic               premio_vld;
  logic [CNT_W-1:0]   p1;
  logic [CNT_W-1:0]   p2;
  logic               busy;
  logic               erro;

  modport master (
    output cfg_we, cfg_idx, cfg_val, numero, insere, fim_jogo,
    input  insere_rdy, premio, premio_vld, p1, p2, busy, erro
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_val, numero, insere, fim_jogo,
    output insere_rdy, premio, premio_vld, p1, p2, busy, erro
  );
endinterface

// File: rtl/loteria_sequenciador.sv
// rtl/loteria_sequenciador.sv - sequences one lottery game: draw load, bet collection, prize classification
// Optional digit range check (0..9) enabled by defining LOTERIA_DIGIT_CHECK_EN.
module loteria_sequenciador #(
  parameter int NUM_DIGITS = 5,
  parameter int DIGIT_W    = 4,
  parameter int CNT_W      = 5,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] SORTEIO_INIT = 20'h53820
) (
  input logic                  clock,
  input logic                  reset,
  loteria_sequenciador_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] RUN_N2   = IDX_W'(NUM_DIGITS - 2);
  localparam logic [IDX_W-1:0] RUN_N3   = IDX_W'(NUM_DIGITS - 3);

  typedef enum logic [1:0] {IDLE, COLLECT, EVAL, REPORT} state_t;

  state_t                             state_q;
  logic [0:NUM_DIGITS-1][DIGIT_W-1:0] draw_q, draw_d;
  logic [IDX_W-1:0]                   idx_q, run_q, max_run_q, run_d, max_run_d;
  logic                               last_hit_q;
  logic [1:0]                         premio_q, class_d;
  logic                               premio_vld_q, busy_q, rdy_q, erro_q;
  logic [CNT_W-1:0]                   p1_q, p2_q;
  logic                               accept, digit_ok, cfg_ok, hit;

`ifdef LOTERIA_DIGIT_CHECK_EN
  assign digit_ok = (bus.numero <= DIGIT_W'(9));
`else
  assign digit_ok = 1'b1;
`endif

  assign accept = bus.insere && rdy_q;
  assign cfg_ok = bus.cfg_we && (state_q == IDLE) && (32'(bus.cfg_idx) < NUM_DIGITS);

  // The draw write is folded in before the compare so a same-cycle position-0 write is seen.
  always_comb begin
    draw_d = draw_q;
    if (cfg_ok) draw_d[IDX_W'(bus.cfg_idx)] = bus.cfg_val;
    hit       = (bus.numero == draw_d[idx_q]);
    run_d     = hit ? run_q + IDX_W'(1) : '0;
    max_run_d = (run_d > max_run_q) ? run_d : max_run_q;
  end

  always_comb begin
    class_d = 2'b00;
    if ((max_run_q == LAST_IDX) || ((max_run_q == RUN_N2) && last_hit_q))
      class_d = 2'b01;
    else if (((max_run_q == RUN_N2) && !last_hit_q) || ((max_run_q == RUN_N3) && last_hit_q))
      class_d = 2'b10;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      draw_q       <= SORTEIO_INIT;
      idx_q        <= '0;
      run_q        <= '0;
      max_run_q    <= '0;
      last_hit_q   <= 1'b0;
      premio_q     <= 2'b00;
      premio_vld_q <= 1'b0;
      p1_q         <= '0;
      p2_q         <= '0;
      busy_q       <= 1'b0;
      rdy_q        <= 1'b1;
      erro_q       <= 1'b0;
    end else begin
      premio_vld_q <= 1'b0;
      erro_q       <= 1'b0;
      draw_q       <= draw_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (digit_ok) begin
              idx_q     <= IDX_W'(1);
              run_q     <= run_d;
              max_run_q <= max_run_d;
              busy_q    <= 1'b1;
              state_q   <= COLLECT;
            end else begin
              erro_q <= 1'b1;
            end
          end
        end
        COLLECT: begin
          // Abort wins over any digit offered in the same cycle.
          if (bus.fim_jogo) begin
            premio_q     <= 2'b00;
            premio_vld_q <= 1'b1;
            rdy_q        <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= REPORT;
          end else if (accept) begin
            if (!digit_ok) begin
              erro_q <= 1'b1;
            end else if (idx_q == LAST_IDX) begin
              last_hit_q <= hit;
              rdy_q      <= 1'b0;
              state_q    <= EVAL;
            end else begin
              idx_q     <= idx_q + IDX_W'(1);
              run_q     <= run_d;
              max_run_q <= max_run_d;
            end
          end
        end
        EVAL: begin
          premio_q     <= class_d;
          premio_vld_q <= 1'b1;
          busy_q       <= 1'b0;
          if (class_d == 2'b01 && p1_q != '1) p1_q <= p1_q + CNT_W'(1);
          if (class_d == 2'b10 && p2_q != '1) p2_q <= p2_q + CNT_W'(1);
          state_q      <= REPORT;
        end
        REPORT: begin
          idx_q      <= '0;
          run_q      <= '0;
          max_run_q  <= '0;
          last_hit_q <= 1'b0;
          rdy_q      <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.insere_rdy = rdy_q;
  assign bus.premio     = premio_q;
  assign bus.premio_vld = premio_vld_q;
  assign bus.p1         = p1_q;
  assign bus.p2         = p2_q;
  assign bus.busy       = busy_q;
  assign bus.erro       = erro_q;
endmodule

// File: doc/loteria_sequenciador.md
Name: loteria_sequenciador

Overview:
- Controller that sequences one lottery game.
- Loads the draw digits, accepts bet digits one per handshake, and tracks per-position matches and the longest consecutive run.
- At end of game, classifies the prize and updates saturating prize counters.
- Sits between the bet-entry front end and the prize display/statistics logic. A new game arms automatically after each report.

Parameters:
- NUM_DIGITS, 5, digits per draw/bet (≥3).
- DIGIT_W, 4, bits per digit.
- CNT_W, 5, width of the p1/p2 prize counters.
- SORTEIO_INIT, 20'h53820, reset value of the draw register, digit 0 in the MS nibble.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_we  in  1  draw-digit write strobe.
- cfg_idx  in  3  draw-digit index, 0..NUM_DIGITS-1.
- cfg_val  in  DIGIT_W  draw-digit value.
- numero  in  DIGIT_W  bet digit.
- insere  in  1  bet digit valid.
- insere_rdy  out  1  controller can accept a digit.
- fim_jogo  in  1  end/abort game request (level, sampled each cycle).
- premio  out  2  00 none, 01 prize 1, 10 prize 2; 11 never driven.
- premio_vld  out  1  one-cycle pulse; premio valid.
- p1  out  CNT_W  prize-1 count.
- p2  out  CNT_W  prize-2 count.
- busy  out  1  game in progress (COLLECT/EVAL).
- erro  out  1  one-cycle pulse on rejected digit (optional feature only; else tied 0).

Behaviour:
- Reset (reset=0, async):
  - State IDLE; draw register = SORTEIO_INIT; idx=0; run=0; max_run=0; last_hit=0.
  - Outputs: premio=00, premio_vld=0, p1=p2=0, busy=0, insere_rdy=1, erro=0.
  - Reset mid-game discards the game; counters clear.
- States: IDLE, COLLECT, EVAL, REPORT.
- IDLE:
  - insere_rdy=1.
  - cfg_we writes draw[cfg_idx] the same edge; cfg_idx ≥ NUM_DIGITS is ignored.
  - A digit accepted (insere & insere_rdy) is processed as position 0 and moves the block to COLLECT.
  - cfg_we and insere in the same cycle: the write is applied first, and the digit compares against the new value only if cfg_idx=0.
- COLLECT:
  - insere_rdy=1; cfg_we ignored; busy=1.
  - Per accepted digit at position idx<NUM_DIGITS-1:
    - hit = (numero==draw[idx]).
    - run = hit ? run+1 : 0.
    - max_run = max(max_run, new run).
  - Digit at idx=NUM_DIGITS-1: last_hit = hit; go to EVAL next edge.
  - idx increments per accepted digit; one digit per cycle maximum.
- fim_jogo handling:
  - fim_jogo=1 in COLLECT before the last digit aborts: any digit that cycle is discarded; go to REPORT with premio forced 00; counters unchanged.
  - fim_jogo in IDLE, EVAL or REPORT is ignored.
- EVAL (1 cycle):
  - insere_rdy=0; busy=1.
  - Classify with R=max_run, L=last_hit, N=NUM_DIGITS:
    - P1 if R==N-1, or (R==N-2 and L).
    - P2 if (R==N-2 and !L), or (R==N-3 and L).
    - Else none.
  - Counters update at the end of EVAL, saturating at 2^CNT_W-1 (no wrap).
- REPORT (1 cycle):
  - premio_vld=1; insere_rdy=0.
  - premio holds its value until the next REPORT or reset.
  - Clears idx, run, max_run and last_hit; returns to IDLE.
- Latency: last digit accepted at edge T → premio_vld high during cycle T+2.
- Only one game is outstanding; digits offered during EVAL/REPORT stall (insere_rdy=0).

Optional Feature:
- Macro: LOTERIA_DIGIT_CHECK_EN.
- Defined: an accepted digit >9 completes the handshake but is dropped.
  - idx, run and max_run are unchanged; erro pulses for 1 cycle.
  - fim_jogo still has priority over a digit in the same cycle.
- Undefined: every DIGIT_W value is accepted and compared; erro tied 0.

Test Plan:
- Default draw, bet 5,3,8,2,0 back-to-back → premio_vld at T+2, premio=01, p1=1, p2=0.
- Bet 5,3,8,9,0 (R=3, L=1) → premio=01. Then bet 5,3,8,9,7 (R=3, L=0) → premio=10, p1=1, p2=1.
- Bet 5,3,1,2,0 (R=2, L=1) → premio=10. Then bet 9,3,1,2,7 → premio=00, counters unchanged.
- cfg_we writes idx3=4 in IDLE, bet 5,3,8,4,0 → premio=01. Also: cfg_we during COLLECT is ignored (draw readback by later game unchanged).
- Two digits, then fim_jogo=1 together with insere → digit discarded, premio_vld with premio=00. Then reset=0 mid-game → all outputs at reset values, draw=53820.
- Run 33 prize-1 games with CNT_W=5 → p1 saturates at 31. With LOTERIA_DIGIT_CHECK_EN: digit 12 → erro pulse, idx not advanced, game completes after 5 valid digits.
